// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM encoding, parity modes, parameter legality.
// Pure declarations; no logic, no latency, no backpressure.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  function automatic bit cfg_legal(input int br, input int half, input int db,
                                   input int par, input int sb, input int depth);
    return (br >= 4) && (half >= 2) && (half < br) &&
           (db >= 5) && (db <= 9) && (par >= PAR_NONE) && (par <= PAR_ODD) &&
           (sb >= 1) && (sb <= 2) && (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line in, FIFO head/pop and error pulses out.
// The master side is the receiver; the slave side is the consumer of words.
interface uart_rx_cfg_if #(parameter int DATA_BITS = 8);
  logic                 sdin;
  logic                 rd_en;
  logic [DATA_BITS-1:0] data;
  logic                 data_rdy;
  logic                 source_ber_framing_error;
  logic                 parity_error;
  logic                 overrun_error;

  modport master (input sdin, rd_en,
                  output data, data_rdy, source_ber_framing_error, parity_error, overrun_error);
  modport slave  (output sdin, rd_en,
                  input data, data_rdy, source_ber_framing_error, parity_error, overrun_error);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive word FIFO; write visible on data_rdy one cycle later, head is combinational.
// A write into a full FIFO is dropped with an overrun pulse unless a pop happens that same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             not_empty,
  output logic             overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      count;
  logic             full, empty, push, pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = rd & ~empty;
  assign push  = wr & (~full | pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= wr & full & ~pop;
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  assign rdata     = empty ? '0 : mem[rp];
  assign not_empty = ~empty;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop sync, 3-sample majority voter, frame FSM, word FIFO.
// Word reaches FIFO the cycle after the last stop mid-sample; no backpressure, full FIFO drops with overrun.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int BR_PERIOD      = 1831,
  parameter int BR_PERIOD_HALF = 916,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input logic          clk,
  input logic          reset,
  uart_rx_cfg_if.master bus
);
  localparam int CW = $clog2(BR_PERIOD + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  if (!cfg_legal(BR_PERIOD, BR_PERIOD_HALF, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_bad_cfg
    $error("uart_rx_cfg: illegal parameter combination");
  end

  rx_state_t            state_q, state_d;
  logic                 sync1, sync2, line_prev, fall;
  logic [1:0]           sync_warm;
  logic [CW-1:0]        cnt;
  logic                 samp_a, samp_b, vote_due, bit_val, counting;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, par_exp;
  logic                 load_half, shift_en, par_en, stop_adv, fr_err, par_pulse, wr_en;
  logic                 framing_q, parity_q;

  // line_prev only follows real samples once the reset value has flushed out of the synchroniser,
  // so a line that is already low at reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_warm <= 2'b00;
      line_prev <= 1'b0;
    end else begin
      sync1     <= bus.sdin;
      sync2     <= sync1;
      sync_warm <= {sync_warm[0], 1'b1};
      line_prev <= sync_warm[1] ? sync2 : 1'b0;
    end
  end

  assign fall     = line_prev & ~sync2;
  assign counting = (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
  assign bit_val  = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
  assign par_exp  = (^shreg) ^ (PARITY == PAR_ODD);

  always_comb begin
    state_d   = state_q;
    load_half = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_adv  = 1'b0;
    fr_err    = 1'b0;
    par_pulse = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_START;
          load_half = 1'b1;
        end
      end
      ST_START: begin
        if (vote_due) state_d = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (vote_due) begin
          shift_en = 1'b1;
          if (idx == BW'(DATA_BITS - 1))
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (vote_due) begin
          par_en  = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (vote_due) begin
          if (!bit_val) begin
            fr_err  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end else if (idx == BW'(STOP_BITS - 1)) begin
            par_pulse = par_bad;
            wr_en     = ~par_bad;
            // Re-arm immediately so a start edge in this very cycle is not lost.
            if (fall) begin
              state_d   = ST_START;
              load_half = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_adv = 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (sync2) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt       <= '0;
      samp_a    <= 1'b0;
      samp_b    <= 1'b0;
      vote_due  <= 1'b0;
      idx       <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      framing_q <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      framing_q <= fr_err;
      parity_q  <= par_pulse;
      // The vote resolves one cycle after the terminal count, using the live sample as the third vote.
      if (load_half) begin
        cnt      <= CW'(BR_PERIOD_HALF);
        vote_due <= 1'b0;
      end else if (counting) begin
        if (cnt == CW'(1)) samp_a <= sync2;
        if (cnt == '0) begin
          samp_b   <= sync2;
          cnt      <= CW'(BR_PERIOD - 1);
          vote_due <= 1'b1;
        end else begin
          cnt      <= cnt - CW'(1);
          vote_due <= 1'b0;
        end
      end else begin
        vote_due <= 1'b0;
      end
      if (state_d != state_q)       idx <= '0;
      else if (shift_en | stop_adv) idx <= idx + BW'(1);
      if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
      if (load_half)   par_bad <= 1'b0;
      else if (par_en) par_bad <= bit_val ^ par_exp;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr_en),
    .wdata     (shreg),
    .rd        (bus.rd_en),
    .rdata     (bus.data),
    .not_empty (bus.data_rdy),
    .overrun   (bus.overrun_error)
  );

  assign bus.source_ber_framing_error = framing_q;
  assign bus.parity_error             = parity_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: stimulus pushes expected words/pulses, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int BP   = 64;
  localparam int HALF = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus_b ();

  uart_rx_cfg #(.BR_PERIOD(BP), .BR_PERIOD_HALF(HALF), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.master));

  uart_rx_cfg #(.BR_PERIOD(BP), .BR_PERIOD_HALF(HALF), .DATA_BITS(8), .PARITY(1),
                .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.master));

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_dat_a[$];
  logic [7:0] exp_dat_b[$];
  int         exp_ev_a[$];   // 1 framing, 2 parity, 3 overrun
  int         exp_ev_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ev_seen(input bit b, input int code);
    if (b) begin
      if (exp_ev_b.size() == 0) check("b_pulse_unexpected", code, 0);
      else check("b_pulse", code, exp_ev_b.pop_front());
    end else begin
      if (exp_ev_a.size() == 0) check("a_pulse_unexpected", code, 0);
      else check("a_pulse", code, exp_ev_a.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus_a.rd_en && bus_a.data_rdy) begin
        if (exp_dat_a.size() == 0) check("a_read_unexpected", exp_dat_a.size(), 1);
        else check("a_read", bus_a.data, exp_dat_a.pop_front());
      end
      if (bus_b.rd_en && bus_b.data_rdy) begin
        if (exp_dat_b.size() == 0) check("b_read_unexpected", exp_dat_b.size(), 1);
        else check("b_read", bus_b.data, exp_dat_b.pop_front());
      end
      if (bus_a.source_ber_framing_error) ev_seen(1'b0, 1);
      if (bus_a.parity_error)             ev_seen(1'b0, 2);
      if (bus_a.overrun_error)            ev_seen(1'b0, 3);
      if (bus_b.source_ber_framing_error) ev_seen(1'b1, 1);
      if (bus_b.parity_error)             ev_seen(1'b1, 2);
      if (bus_b.overrun_error)            ev_seen(1'b1, 3);
    end
  end

  function automatic logic [11:0] frame8(input logic [7:0] d, input logic stop);
    return {2'b11, stop, d, 1'b0};
  endfunction

  function automatic logic [11:0] framep(input logic [7:0] d, input logic p);
    return {2'b11, p, d, 1'b0};
  endfunction

  task automatic tx(input bit b, input logic [11:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      if (b) bus_b.sdin = seq[i];
      else   bus_a.sdin = seq[i];
      repeat (BP) @(posedge clk);
    end
  endtask

  task automatic idle(input int bits);
    repeat (bits * BP) @(posedge clk);
  endtask

  task automatic rd(input bit b);
    int n = 0;
    while (((b ? bus_b.data_rdy : bus_a.data_rdy) !== 1'b1) && n < 12 * BP) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(b ? "b_rdy_before_read" : "a_rdy_before_read", b ? bus_b.data_rdy : bus_a.data_rdy, 1);
    @(posedge clk);
    #1;
    if (b) bus_b.rd_en = 1'b1; else bus_a.rd_en = 1'b1;
    @(posedge clk);
    #1;
    bus_a.rd_en = 1'b0;
    bus_b.rd_en = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus_a.sdin = 1'b1; bus_a.rd_en = 1'b0;
    bus_b.sdin = 1'b1; bus_b.rd_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy_a", bus_a.data_rdy, 0);
    check("rst_data_a", bus_a.data, 0);
    check("rst_fe_a", bus_a.source_ber_framing_error, 0);
    check("rst_pe_a", bus_a.parity_error, 0);
    check("rst_ov_a", bus_a.overrun_error, 0);
    check("rst_rdy_b", bus_b.data_rdy, 0);
    @(posedge clk); #1 reset = 1'b1;
    idle(2);

    // single 8N1 frame of all-zero data
    exp_dat_a.push_back(8'h00);
    tx(0, frame8(8'h00, 1'b1), 10);
    idle(1);
    rd(0);

    // two back-to-back frames, read afterwards
    exp_dat_a.push_back(8'h01);
    exp_dat_a.push_back(8'hA5);
    tx(0, frame8(8'h01, 1'b1), 10);
    tx(0, frame8(8'hA5, 1'b1), 10);
    idle(1);
    rd(0);
    @(negedge clk) check("one_left_after_first_read", bus_a.data_rdy, 1);
    rd(0);
    @(negedge clk) check("empty_after_two_reads", bus_a.data_rdy, 0);

    // 30-cycle glitch on the idle line
    bus_a.sdin = 1'b0;
    repeat (30) @(posedge clk);
    bus_a.sdin = 1'b1;
    idle(2);
    @(negedge clk);
    check("glitch_no_write", bus_a.data_rdy, 0);
    check("glitch_back_idle", dut_a.state_q, ST_IDLE);

    // bad stop bit followed by a 20-bit break
    exp_ev_a.push_back(1);
    tx(0, frame8(8'h55, 1'b0), 10);
    idle(20);
    @(negedge clk);
    check("framing_pulse_seen", exp_ev_a.size(), 0);
    check("framing_no_write", bus_a.data_rdy, 0);
    bus_a.sdin = 1'b1;
    idle(2);
    exp_dat_a.push_back(8'h3A);
    tx(0, frame8(8'h3A, 1'b1), 10);
    idle(1);
    rd(0);

    // five frames into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_dat_a.push_back(8'(8'h10 + i));
      else       exp_ev_a.push_back(3);
      tx(0, frame8(8'(8'h10 + i), 1'b1), 10);
    end
    idle(1);
    @(negedge clk) check("overrun_pulse_seen", exp_ev_a.size(), 0);
    for (int i = 0; i < 4; i++) rd(0);
    @(negedge clk) check("empty_after_drain", bus_a.data_rdy, 0);

    // even parity: 0xA5 has four ones, so a parity bit of 1 is wrong
    exp_ev_b.push_back(2);
    tx(1, framep(8'hA5, 1'b1), 11);
    idle(1);
    @(negedge clk);
    check("parity_pulse_seen", exp_ev_b.size(), 0);
    check("parity_no_write", bus_b.data_rdy, 0);
    exp_dat_b.push_back(8'hA5);
    tx(1, framep(8'hA5, 1'b0), 11);
    idle(1);
    rd(1);

    // reset in the middle of data bit 4, with a word already waiting
    tx(0, frame8(8'h5A, 1'b1), 10);
    idle(1);
    @(negedge clk) check("word_waiting_pre_reset", bus_a.data_rdy, 1);
    tx(0, frame8(8'h77, 1'b1), 5);
    bus_a.sdin = 1'b1;
    repeat (BP / 2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_rdy", bus_a.data_rdy, 0);
    check("midreset_data", bus_a.data, 0);
    check("midreset_fe", bus_a.source_ber_framing_error, 0);
    check("midreset_state", dut_a.state_q, ST_IDLE);
    bus_a.sdin = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    idle(3);
    bus_a.sdin = 1'b1;
    @(negedge clk) check("low_line_no_frame", bus_a.data_rdy, 0);
    idle(2);
    exp_dat_a.push_back(8'h3C);
    tx(0, frame8(8'h3C, 1'b1), 10);
    idle(1);
    rd(0);

    idle(2);
    check("a_words_left", exp_dat_a.size(), 0);
    check("a_pulses_left", exp_ev_a.size(), 0);
    check("b_words_left", exp_dat_b.size(), 0);
    check("b_pulses_left", exp_ev_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
